// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART TX arbiter
//
// Purpose : arbiter FSM state type, header tag constant and index-width helper.
// Optional: UART_ARB_ID_HEADER_EN (the HDR state is only entered when defined).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2
  } arbState_t;

  // Upper nibble of the per-packet ID header byte.
  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic int idx_width(input int numReq);
    return (numReq <= 1) ? 1 : $clog2(numReq);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Purpose : pick the first set bit of valid, searching upward from lastIdx+1
//           and wrapping modulo NUM_REQ.
// Ports   : valid   [NUM_REQ] request vector
//           lastIdx [IW]      most recently served index (lowest priority)
//           sel     [IW]      picked index (0 when nothing is valid)
//           any               at least one request is valid
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      lastIdx,
  output logic [IW-1:0]      sel,
  output logic               any
);

  logic found;

  assign any = |valid;

  // k runs 1..NUM_REQ so lastIdx itself is visited last.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && valid[(int'(lastIdx) + k) % NUM_REQ]) begin
        sel   = IW'((int'(lastIdx) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter for the UART TX FIFO
//
// Purpose : shares the UART TX FIFO write port between NUM_REQ byte streams.
//           A grant is held from the first byte until the Last byte is taken;
//           an idle watchdog drops a grant whose owner stalls mid-packet.
// Optional: UART_ARB_ID_HEADER_EN - prefix every packet with {HDR_TAG, index}.
// Ports   : Clock, ResetN (async, active low)
//           ReqValid/ReqLast [NUM_REQ], ReqData [NUM_REQ*DATA_BITS] - requesters
//           ReqReady [NUM_REQ] - byte taken this cycle (one-hot or zero)
//           TxFull - FIFO full; WriteUart/WriteData - FIFO write port
//           Grant [NUM_REQ] - current owner; Busy - packet in progress
//           Abort - one-cycle pulse when the watchdog releases a grant
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int IDLE_TIMEOUT = 255,
  parameter int TO_BITS      = 8
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  input  logic [NUM_REQ-1:0]           ReqValid,
  input  logic [NUM_REQ-1:0]           ReqLast,
  input  logic [NUM_REQ*DATA_BITS-1:0] ReqData,
  output logic [NUM_REQ-1:0]           ReqReady,
  input  logic                         TxFull,
  output logic                         WriteUart,
  output logic [DATA_BITS-1:0]         WriteData,
  output logic [NUM_REQ-1:0]           Grant,
  output logic                         Busy,
  output logic                         Abort
);

  localparam int IW = idx_width(NUM_REQ);

  arbState_t          state;
  // lastIdx doubles as the granted index while a packet is in progress.
  logic [IW-1:0]      lastIdx;
  logic [TO_BITS-1:0] toCnt;
  logic [TO_BITS-1:0] toNext;
  logic [IW-1:0]      pickSel;
  logic               pickAny;
  logic               ownValid;
  logic               accept;
  logic               hdrWrite;
  logic               wdFire;
  logic [DATA_BITS-1:0] hdrByte;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .valid   (ReqValid),
    .lastIdx (lastIdx),
    .sel     (pickSel),
    .any     (pickAny)
  );

  assign ownValid = ReqValid[lastIdx];
  assign accept   = (state == STREAM) && ownValid && !TxFull;
  assign toNext   = toCnt + TO_BITS'(1);
  // Only cycles where the owner has nothing to send count; FIFO stalls do not.
  assign wdFire   = (IDLE_TIMEOUT != 0) && (state == STREAM) && !ownValid &&
                    (toNext == TO_BITS'(IDLE_TIMEOUT));

`ifdef UART_ARB_ID_HEADER_EN
  logic [7:0] hdrFull;
  assign hdrFull  = {HDR_TAG, 4'(lastIdx)};
  assign hdrByte  = DATA_BITS'(hdrFull);
  assign hdrWrite = (state == HDR) && !TxFull;
`else
  assign hdrByte  = '0;
  assign hdrWrite = 1'b0;
`endif

  always_comb begin
    ReqReady  = '0;
    WriteUart = accept | hdrWrite;
    WriteData = '0;
    if (accept) begin
      ReqReady  = NUM_REQ'(1) << lastIdx;
      WriteData = ReqData[int'(lastIdx)*DATA_BITS +: DATA_BITS];
    end else if (hdrWrite) begin
      WriteData = hdrByte;
    end
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      Grant   <= '0;
      Abort   <= 1'b0;
      toCnt   <= '0;
      lastIdx <= IW'(NUM_REQ - 1);
    end else begin
      Abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pickAny) begin
            Grant   <= NUM_REQ'(1) << pickSel;
            lastIdx <= pickSel;
            toCnt   <= '0;
`ifdef UART_ARB_ID_HEADER_EN
            state   <= HDR;
`else
            state   <= STREAM;
`endif
          end
        end
`ifdef UART_ARB_ID_HEADER_EN
        HDR: begin
          if (!TxFull) state <= STREAM;
        end
`endif
        STREAM: begin
          if (accept) begin
            toCnt <= '0;
            if (ReqLast[lastIdx]) begin
              state <= IDLE;
              Grant <= '0;
            end
          end else if (wdFire) begin
            state <= IDLE;
            Grant <= '0;
            Abort <= 1'b1;
            toCnt <= '0;
          end else if (!ownValid) begin
            toCnt <= toNext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
